// File: rtl/cache_wb_controller.sv
// Direct-mapped write-back / write-allocate cache controller: 4 one-word lines
// in front of a 32 x 16 main memory, with dirty-line flush.
module cache_wb_controller #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int LINES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  input  logic              flush,
  output logic              flush_done,
  output logic              mm_re,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL,
    FILL_WAIT,
    FLUSH
  } state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic              req_wr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic              first_lookup;
  logic [IDX_W-1:0]  scan;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              flush_wr;

  assign idx      = req_addr_q[IDX_W-1:0];
  assign req_tag  = req_addr_q[ADDR_W-1:IDX_W];
  assign hit      = valid[idx] && (tag_mem[idx] == req_tag);
  assign flush_wr = (state == FLUSH) && valid[scan] && dirty[scan];
  assign req_ready = (state == IDLE) && !flush;

  // Memory strobes are decoded from registered state only, so they are
  // glitch-free and drop to zero the moment reset forces IDLE.
  // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mm_re    = 1'b0;
    mm_we    = 1'b0;
    mm_addr  = '0;
    mm_wdata = '0;
    case (state)
      WRITEBACK: begin
        mm_we    = 1'b1;
        mm_addr  = {tag_mem[idx], idx};
        mm_wdata = data_mem[idx];
      end
      FILL: begin
        mm_re   = 1'b1;
        mm_addr = req_addr_q;
      end
      FLUSH: begin
        if (flush_wr) begin
          mm_we    = 1'b1;
          mm_addr  = {tag_mem[scan], scan};
          mm_wdata = data_mem[scan];
        end
      end
      default: ;
    endcase
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether
  // their contents mean anything, and leaving them unreset keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_wr_q) begin
      data_mem[idx] <= req_wdata_q;
    end else if (state == FILL_WAIT) begin
      data_mem[idx] <= mm_rdata;
      tag_mem[idx]  <= req_tag;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      req_wr_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      first_lookup <= 1'b0;
      scan         <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_hit     <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            scan  <= '0;
            state <= FLUSH;
          end else if (req_valid && req_ready) begin
            req_wr_q     <= req_write;
            req_addr_q   <= req_addr;
            req_wdata_q  <= req_wdata;
            first_lookup <= 1'b1;
            state        <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= first_lookup;
            resp_rdata <= req_wr_q ? req_wdata_q : data_mem[idx];
            if (req_wr_q) dirty[idx] <= 1'b1;
            state <= IDLE;
          end else begin
            first_lookup <= 1'b0;
            state <= (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: state <= FILL;
        FILL:      state <= FILL_WAIT;
        FILL_WAIT: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= COMPARE;
        end
        FLUSH: begin
          if (flush_wr) dirty[scan] <= 1'b0;
          if (scan == IDX_W'(LINES - 1)) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            scan <= scan + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_wb_controller.sv
// Directed bench for cache_wb_controller: behavioural 32x16 main memory with a
// strobe log, hand-computed latencies, data and write-back ordering.
module tb_cache_wb_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_hit;
  logic        flush;
  logic        flush_done;
  logic        mm_re;
  logic        mm_we;
  logic [4:0]  mm_addr;
  logic [15:0] mm_wdata;
  logic [15:0] mm_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t         evq[$];
  logic [15:0] mem [32];
  int          both_cnt = 0;

  cache_wb_controller dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .flush      (flush),
    .flush_done (flush_done),
    .mm_re      (mm_re),
    .mm_we      (mm_we),
    .mm_addr    (mm_addr),
    .mm_wdata   (mm_wdata),
    .mm_rdata   (mm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [4:0] a);
    case (a)
      5'd2:    return 16'hBEEF;
      5'd4:    return 16'h0404;
      5'd5:    return 16'hABCD;
      5'd9:    return 16'h0909;
      5'd13:   return 16'h1313;
      5'd29:   return 16'h2929;
      default: return 16'hC000 | 16'(a);
    endcase
  endfunction

  // Main memory model: read data one cycle after mm_re; every strobe logged.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(5'(i));
    end else begin
      if (mm_we) mem[mm_addr] <= mm_wdata;
      if (mm_re) mm_rdata <= mem[mm_addr];
    end
    if (mm_re || mm_we) evq.push_back({mm_we, mm_addr, mm_wdata});
    if (mm_re && mm_we) both_cnt++;
  end

  function automatic ev_t ev_at(input int i);
    if (i >= 0 && i < evq.size()) return evq[i];
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle. lat = edges after accept
  // until resp_valid is seen (-1 on timeout).
  task automatic do_req(input logic wr, input logic [4:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rdata, output logic hit,
                        output int first_ev, output int n_ev);
    first_ev  = evq.size();
    lat       = -1;
    rdata     = 'x;
    hit       = 1'bx;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~a;
    req_wdata = ~d;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat   = k;
        rdata = resp_rdata;
        hit   = resp_hit;
        break;
      end
    end
    n_ev = evq.size() - first_ev;
  endtask

  task automatic do_flush(input logic with_req, output int lat, output logic rdy,
                          output logic resp_seen, output int first_ev, output int n_ev);
    first_ev  = evq.size();
    lat       = -1;
    resp_seen = 1'b0;
    flush     = 1'b1;
    if (with_req) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 5'd5;
    end
    #1 rdy = req_ready;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) resp_seen = 1'b1;
      if (flush_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_ev = evq.size() - first_ev;
  endtask

  initial begin
    int          lat;
    int          fe;
    int          ne;
    logic [15:0] rd;
    logic        ht;
    logic        rdy;
    logic        rs;
    ev_t         e;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_mm_re", mm_re, 0);
    check("rst_mm_we", mm_we, 0);

    // Flush with nothing dirty
    do_flush(1'b0, lat, rdy, rs, fe, ne);
    check("flush0_ready_low", rdy, 0);
    check("flush0_done_lat", lat, 4);
    check("flush0_mm_ops", ne, 0);
    check("flush0_no_resp", rs, 0);

    // Clean read miss on 5
    do_req(1'b0, 5'd5, 16'h0, lat, rd, ht, fe, ne);
    check("rd5_miss_lat", lat, 4);
    check("rd5_miss_data", rd, 16'hABCD);
    check("rd5_miss_hit", ht, 0);
    check("rd5_miss_ops", ne, 1);
    e = ev_at(fe);
    check("rd5_fill_is_read", e.we, 0);
    check("rd5_fill_addr", e.addr, 5);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 0);

    // Read hit, then write hit, on 5
    do_req(1'b0, 5'd5, 16'h0, lat, rd, ht, fe, ne);
    check("rd5_hit_lat", lat, 1);
    check("rd5_hit_data", rd, 16'hABCD);
    check("rd5_hit_hit", ht, 1);
    check("rd5_hit_ops", ne, 0);
    do_req(1'b1, 5'd5, 16'h1234, lat, rd, ht, fe, ne);
    check("wr5_hit_lat", lat, 1);
    check("wr5_hit_echo", rd, 16'h1234);
    check("wr5_hit_hit", ht, 1);
    check("wr5_hit_ops", ne, 0);

    // Dirty miss: read 9 evicts dirty 5
    do_req(1'b0, 5'd9, 16'h0, lat, rd, ht, fe, ne);
    check("rd9_dirty_lat", lat, 5);
    check("rd9_data", rd, 16'h0909);
    check("rd9_hit", ht, 0);
    check("rd9_ops", ne, 2);
    e = ev_at(fe);
    check("rd9_wb_is_write", e.we, 1);
    check("rd9_wb_addr", e.addr, 5);
    check("rd9_wb_data", e.data, 16'h1234);
    e = ev_at(fe + 1);
    check("rd9_fill_is_read", e.we, 0);
    check("rd9_fill_addr", e.addr, 9);
    check("mem5_written", mem[5], 16'h1234);

    // Write miss allocates on 2, then reads back
    do_req(1'b1, 5'd2, 16'h00FF, lat, rd, ht, fe, ne);
    check("wr2_miss_lat", lat, 4);
    check("wr2_miss_echo", rd, 16'h00FF);
    check("wr2_miss_hit", ht, 0);
    check("wr2_miss_ops", ne, 1);
    e = ev_at(fe);
    check("wr2_fill_addr", e.addr, 2);
    do_req(1'b0, 5'd2, 16'h0, lat, rd, ht, fe, ne);
    check("rd2_hit_lat", lat, 1);
    check("rd2_hit_data", rd, 16'h00FF);
    check("rd2_hit_hit", ht, 1);

    // Dirty line at index 0 via write miss on 4
    do_req(1'b1, 5'd4, 16'h4444, lat, rd, ht, fe, ne);
    check("wr4_miss_lat", lat, 4);
    check("wr4_miss_hit", ht, 0);

    // Flush concurrent with a request: flush wins, two write-backs in index order
    do_flush(1'b1, lat, rdy, rs, fe, ne);
    check("flush1_ready_low", rdy, 0);
    check("flush1_done_lat", lat, 4);
    check("flush1_no_resp", rs, 0);
    check("flush1_ops", ne, 2);
    e = ev_at(fe);
    check("flush1_wb0_we", e.we, 1);
    check("flush1_wb0_addr", e.addr, 4);
    check("flush1_wb0_data", e.data, 16'h4444);
    e = ev_at(fe + 1);
    check("flush1_wb1_we", e.we, 1);
    check("flush1_wb1_addr", e.addr, 2);
    check("flush1_wb1_data", e.data, 16'h00FF);

    do_flush(1'b0, lat, rdy, rs, fe, ne);
    check("flush2_done_lat", lat, 4);
    check("flush2_ops", ne, 0);

    // Lines stay valid and clean after flush
    do_req(1'b0, 5'd2, 16'h0, lat, rd, ht, fe, ne);
    check("rd2_postflush_lat", lat, 1);
    check("rd2_postflush_data", rd, 16'h00FF);
    check("rd2_postflush_ops", ne, 0);

    // Index aliasing at the top address
    do_req(1'b0, 5'd29, 16'h0, lat, rd, ht, fe, ne);
    check("rd29_lat", lat, 4);
    check("rd29_data", rd, 16'h2929);
    check("rd29_ops", ne, 1);
    e = ev_at(fe);
    check("rd29_fill_addr", e.addr, 29);
    do_req(1'b0, 5'd9, 16'h0, lat, rd, ht, fe, ne);
    check("rd9_alias_lat", lat, 4);
    check("rd9_alias_data", rd, 16'h0909);
    check("rd9_alias_hit", ht, 0);

    // Reset during FILL_WAIT of a read of 13
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fe  = evq.size();
    rs  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) rs = 1'b1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || flush_done !== 1'b0) rs = 1'b1;
    end
    check("rst_mid_no_pulse", rs, 0);
    check("rst_mid_no_ops", evq.size() - fe, 0);

    do_req(1'b0, 5'd13, 16'h0, lat, rd, ht, fe, ne);
    check("rd13_after_rst_lat", lat, 4);
    check("rd13_after_rst_data", rd, 16'h1313);
    check("rd13_after_rst_hit", ht, 0);
    check("rd13_after_rst_ops", ne, 1);
    e = ev_at(fe);
    check("rd13_fill_addr", e.addr, 13);
    do_req(1'b0, 5'd2, 16'h0, lat, rd, ht, fe, ne);
    check("rd2_after_rst_lat", lat, 4);
    check("rd2_after_rst_data", rd, 16'hBEEF);

    check("mm_re_we_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_wb_controller.md
# cache_wb_controller

Direct-mapped, write-back, write-allocate cache controller sitting between a requester and the 32 x 16 main memory. It is the return path of the read-fill controller. It accepts read/write requests over a valid/ready handshake and serves hits from a 4-line cache array. On a miss it writes the dirty victim line back to main memory, then refills the line. A flush command drains every dirty line to main memory.

## Interface
- ADDR_W, 5, main-memory address width; index = addr[1:0] (addr % 4), tag = addr[ADDR_W-1:2]
- DATA_W, 16, word width; one word per line
- LINES, 4, number of cache lines (fixed to 2^2)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- req_ready  out  1  combinational; = (state == IDLE) && !flush
- resp_valid  out  1  registered one-cycle pulse; request completed
- resp_rdata  out  DATA_W  registered; read data (written data echoed for writes)
- resp_hit  out  1  registered with resp_valid; 1 if the first lookup hit
- flush  in  1  level; start flush when sampled in IDLE
- flush_done  out  1  registered one-cycle pulse; flush complete
- mm_re  out  1  main-memory read enable
- mm_we  out  1  main-memory write enable
- mm_addr  out  ADDR_W  main-memory address
- mm_wdata  out  DATA_W  main-memory write data
- mm_rdata  in  DATA_W  main-memory read data; valid the cycle after mm_re

## Operation
- Per line: valid, dirty, tag[2:0], data[15:0].
- Reset clears all valid and dirty bits, state = IDLE, and sets all registered outputs to 0. mm_re, mm_we, mm_addr and mm_wdata are 0 in IDLE.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL, FILL_WAIT, FLUSH.
- IDLE:
  - flush=1 -> FLUSH with the scan index at 0. Flush has priority over req_valid.
  - Otherwise, req_valid && req_ready -> latch write, addr and wdata, then go to COMPARE.
- COMPARE: hit = valid[idx] && tag[idx] == addr tag.
  - Read hit: resp_rdata <= data[idx].
  - Write hit: data[idx] <= wdata, dirty[idx] <= 1, resp_rdata <= wdata.
  - On either hit: resp_valid <= 1, resp_hit <= first-lookup flag, go to IDLE.
  - Miss with valid && dirty victim -> WRITEBACK. Other misses -> FILL. Clear the first-lookup flag.
- WRITEBACK (one cycle): mm_we=1, mm_addr={victim tag, idx}, mm_wdata=data[idx]. Then go to FILL.
- FILL (one cycle): mm_re=1, mm_addr=request addr. Then go to FILL_WAIT.
- FILL_WAIT: data[idx] <= mm_rdata, tag <= request tag, valid <= 1, dirty <= 0. Then go to COMPARE, which now hits (write-allocate: a write miss merges its data in COMPARE).
- FLUSH (one cycle per index, 0..3):
  - If the line at the scan index is valid && dirty: mm_we=1, mm_addr={tag, index}, mm_wdata=data, and clear dirty. Valid is kept.
  - After index 3: flush_done <= 1, go to IDLE.
- mm_re and mm_we are never asserted together. Each is asserted for exactly one cycle per access.

## Timing
- Accept edge = E0 (req_valid && req_ready sampled high).
- Hit: resp_valid high after E1 (1-edge latency, 2 cycles including the accept cycle).
- Clean miss: COMPARE, FILL, FILL_WAIT, COMPARE; resp_valid after E4.
- Dirty miss: adds WRITEBACK; resp_valid after E5. The write-back cycle always precedes the fill read.
- resp_valid coincides with the return to IDLE, so req_ready is high in the same cycle. A new request may be accepted while resp_valid is high (back-to-back hits give one response every 2 cycles).
- Flush: exactly 4 FLUSH cycles regardless of dirty count. flush_done pulses in the first IDLE cycle after the scan.
- Request fields are latched at E0. Changes to req_* after acceptance are ignored.
- Reset mid-operation (any state): return to IDLE immediately and invalidate all lines. No further mm_re or mm_we is issued and no resp_valid or flush_done pulse is produced. Dirty data is discarded.
- Address wrap: addresses 0..31 only. Index aliasing (e.g. 1, 5, 9, ..., 29) is resolved solely by tag compare.

## Test plan
- Reset, then idle: req_ready=1. resp_valid, resp_hit, flush_done, mm_re and mm_we all 0. A flush with no dirty lines gives 4 cycles and no mm_we, then flush_done.
- Read miss on addr 5 with MM[5]=0xABCD -> one mm_re at addr 5; resp_valid 4 edges after accept with rdata=0xABCD, hit=0. Re-read addr 5 -> resp 1 edge after accept, hit=1, no MM access.
- Write 0x1234 to addr 5 (hit), then read addr 9 (same index 1) with MM[9]=0x0909 -> mm_we addr 5 data 0x1234, next cycle mm_re addr 9; resp rdata=0x0909 after E5, hit=0.
- Write miss to addr 2, data 0x00FF -> fill read at addr 2, line dirty, resp hit=0. A following read of addr 2 returns 0x00FF with hit=1.
- Dirty lines at index 0 (addr 4) and index 2 (addr 2), flush and req_valid asserted together -> flush wins. Exactly two mm_we (addr 4, then addr 2), flush_done after the 4th scan cycle. A later flush issues no writes.
- Assert rst during FILL_WAIT -> no resp_valid and no further MM strobes. A subsequent read of the same address misses again (mm_re reissued).
